// File: rtl/cmp_seq_if.sv
// Start/done handshake bundle for cmp_seq: operands in, status and result flags out.
interface cmp_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic             aeqb;
    logic             agtb;
    logic             altb;

    // Requester side: issues operands, observes status and flags.
    modport master (
        output start, a, b,
        input  ready, busy, done, aeqb, agtb, altb
    );

    // Comparator side.
    modport slave (
        input  start, a, b,
        output ready, busy, done, aeqb, agtb, altb
    );
endinterface

// File: rtl/cmp_seq.sv
// cmp_seq: sequential magnitude comparator, one DIGIT-bit slice per cycle from the MSB,
// stopping at the first differing slice.
// Optional feature macro: CMP_SIGNED_EN (two's-complement operands). When it is defined,
// the capture path sign-extends and flips the top bit so the unsigned slice compare
// yields signed ordering; the compare logic is the same in both builds.
module cmp_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    cmp_seq_if.slave  bus
);
    localparam int unsigned NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int unsigned EW   = NDIG * DIGIT;
    localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [EW-1:0]   a_q;
    logic [EW-1:0]   b_q;
    logic [IW-1:0]   idx;
    logic            aeqb_q;
    logic            agtb_q;
    logic            altb_q;

    logic            accept_c;
    logic [DIGIT-1:0] sa_c;
    logic [DIGIT-1:0] sb_c;
    logic            diff_c;
    logic            last_c;
    logic [EW-1:0]   a_ext_c;
    logic [EW-1:0]   b_ext_c;

    // Operand conditioning at capture: extension (and bias flip for signed builds).
    always_comb begin
`ifdef CMP_SIGNED_EN
        a_ext_c = EW'($signed(bus.a));
        b_ext_c = EW'($signed(bus.b));
        a_ext_c[EW-1] = ~a_ext_c[EW-1];
        b_ext_c[EW-1] = ~b_ext_c[EW-1];
`else
        a_ext_c = EW'(bus.a);
        b_ext_c = EW'(bus.b);
`endif
    end

    // Current slice compare and handshake acceptance.
    always_comb begin
        sa_c     = a_q[DIGIT * 32'(idx) +: DIGIT];
        sb_c     = b_q[DIGIT * 32'(idx) +: DIGIT];
        diff_c   = (sa_c != sb_c);
        last_c   = diff_c || (idx == '0);
        accept_c = (state != S_RUN) && bus.start;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (last_c)    state_nxt = S_DONE;
            S_DONE:  state_nxt = bus.start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, slice index walk and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            aeqb_q <= 1'b0;
            agtb_q <= 1'b0;
            altb_q <= 1'b0;
        end else if (accept_c) begin
            a_q <= a_ext_c;
            b_q <= b_ext_c;
            idx <= IW'(NDIG - 1);
        end else if (state == S_RUN) begin
            if (diff_c) begin
                aeqb_q <= 1'b0;
                agtb_q <= (sa_c > sb_c);
                altb_q <= (sa_c < sb_c);
            end else if (idx == '0) begin
                aeqb_q <= 1'b1;
                agtb_q <= 1'b0;
                altb_q <= 1'b0;
            end else begin
                idx <= idx - IW'(1);
            end
        end
    end

    // Output decode from the registered state and flags.
    always_comb begin
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.aeqb  = aeqb_q;
        bus.agtb  = agtb_q;
        bus.altb  = altb_q;
        case (state)
            S_IDLE:  bus.ready = 1'b1;
            S_RUN:   bus.busy  = 1'b1;
            S_DONE:  begin
                bus.ready = 1'b1;
                bus.done  = 1'b1;
            end
            default: bus.ready = 1'b0;
        endcase
    end
endmodule
